// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : opcodes, instruction field positions and ALU select encoding
//           shared by the 8-bit core and its register file.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 24;
  localparam int RD_MSB  = 18;
  localparam int RD_LSB  = 16;
  localparam int RT_MSB  = 10;
  localparam int RT_LSB  = 8;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_AND  = 2'd2,
    ALU_OR   = 2'd3
  } alu_sel_e;

endpackage

`default_nettype wire

// File: rtl/reg_file_8x8.sv
// ---------------------------------------------------------------------------
// reg_file_8x8 : 8 x 8-bit registers, two asynchronous read ports, one
//                synchronous write port, synchronous active-low clear.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module reg_file_8x8 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [2:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [2:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [2:0] i_raddr_b,
  output logic [7:0] o_rdata_b
);

  logic [7:0] regArr [8];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regArr[i] <= 8'h00;
      end
    end else if (i_we) begin
      regArr[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = regArr[i_raddr_a];
  assign o_rdata_b = regArr[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/cpu_core_8bit.sv
// ---------------------------------------------------------------------------
// cpu_core_8bit : single-cycle 8-bit core, one 32-bit instruction per edge,
//                 combinational decode/ALU, clocked PC and write-back only.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cpu_core_8bit
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] PC
);

  logic [31:0] r_pc;
  logic [7:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rt;
  logic [2:0]  w_rs;
  logic [7:0]  w_imm;
  logic [7:0]  w_rt_data;
  logic [7:0]  w_rs_data;
  logic [7:0]  w_src_b;
  logic [7:0]  w_opnd_b;
  logic [7:0]  w_result;
  logic        w_we;
  logic        w_use_imm;
  logic        w_negate;
  alu_sel_e    w_alu_sel;
  logic        w_unused_bits;

  assign w_op          = INSTRUCTION[OP_MSB:OP_LSB];
  assign w_rd          = INSTRUCTION[RD_MSB:RD_LSB];
  assign w_rt          = INSTRUCTION[RT_MSB:RT_LSB];
  assign w_rs          = INSTRUCTION[RS_MSB:RS_LSB];
  assign w_imm         = INSTRUCTION[IMM_MSB:IMM_LSB];
  assign w_unused_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  always_comb begin
    w_we      = 1'b1;
    w_use_imm = 1'b0;
    w_negate  = 1'b0;
    w_alu_sel = ALU_PASS;
    case (w_op)
      OP_LOADI: w_use_imm = 1'b1;
      OP_MOV:   w_alu_sel = ALU_PASS;
      OP_ADD:   w_alu_sel = ALU_ADD;
      OP_SUB: begin
        w_alu_sel = ALU_ADD;
        w_negate  = 1'b1;
      end
      OP_AND:   w_alu_sel = ALU_AND;
      OP_OR:    w_alu_sel = ALU_OR;
      default:  w_we      = 1'b0;
    endcase
  end

  // Subtraction reuses the adder with a two's-complement second operand
  assign w_src_b  = w_use_imm ? w_imm : w_rs_data;
  assign w_opnd_b = w_negate ? (~w_src_b + 8'd1) : w_src_b;

  always_comb begin
    w_result = w_opnd_b;
    case (w_alu_sel)
      ALU_PASS: w_result = w_opnd_b;
      ALU_ADD:  w_result = w_rt_data + w_opnd_b;
      ALU_AND:  w_result = w_rt_data & w_opnd_b;
      ALU_OR:   w_result = w_rt_data | w_opnd_b;
      default:  w_result = w_opnd_b;
    endcase
  end

  reg_file_8x8 reg_8x8 (
    .i_clk     (CLK),
    .i_rst_n   (RESET),
    .i_we      (w_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_result),
    .i_raddr_a (w_rt),
    .o_rdata_a (w_rt_data),
    .i_raddr_b (w_rs),
    .o_rdata_b (w_rs_data)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign PC = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_cpu_core_8bit.sv
// ---------------------------------------------------------------------------
// tb_cpu_core_8bit : directed programs plus random instruction stream for
//                    cpu_core_8bit, checked against an arithmetic model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_core_8bit;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [7:0]  m_r [8];
  logic [31:0] m_pc;
  bit          model_valid = 0;

  cpu_core_8bit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [7:0] op, input int rd, input int rt, input logic [7:0] rs_imm);
    logic [2:0] d;
    logic [2:0] t;
    d = 3'(rd);
    t = 3'(rt);
    return {op, 5'b0, d, 5'b0, t, rs_imm};
  endfunction

  // Reference: a register array updated with plain modulo-256 arithmetic
  task automatic model_step(input logic rst, input logic [31:0] ins);
    int a;
    int b;
    int d;
    a = int'(m_r[ins[10:8]]);
    b = int'(m_r[ins[2:0]]);
    d = int'(ins[18:16]);
    if (!rst) begin
      m_pc = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    end else begin
      m_pc = m_pc + 32'd4;
      case (ins[31:24])
        8'h00: m_r[d] = ins[7:0];
        8'h01: m_r[d] = 8'(b);
        8'h02: m_r[d] = 8'((a + b) % 256);
        8'h03: m_r[d] = 8'((a - b + 256) % 256);
        8'h04: m_r[d] = 8'(a & b);
        8'h05: m_r[d] = 8'(a | b);
        default: ;
      endcase
    end
  endtask

  // Inputs change 2 time units after each edge, like a fetch from memory
  task automatic exec(input logic rst, input logic [31:0] ins);
    RESET       = rst;
    INSTRUCTION = ins;
    @(posedge CLK);
    model_step(rst, ins);
    model_valid = 1;
    #2;
  endtask

  always @(negedge CLK) begin
    if (model_valid) begin
      chk("pc", PC, m_pc);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("r%0d", i), {24'd0, dut.reg_8x8.regArr[i]}, {24'd0, m_r[i]});
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic        rst;
    RESET       = 1'b1;
    INSTRUCTION = 32'hFF00_0000;
    #2;

    exec(1'b0, 32'hFF00_0000);
    chk("t1_pc_reset", PC, 32'd0);
    exec(1'b1, 32'hFF00_0000); chk("t1_pc4", PC, 32'd4);
    exec(1'b1, 32'hFF00_0000); chk("t1_pc8", PC, 32'd8);
    exec(1'b1, 32'hFF00_0000); chk("t1_pc12", PC, 32'd12);
    chk("t1_r3_zero", {24'd0, dut.reg_8x8.regArr[3]}, 32'd0);

    exec(1'b1, 32'h00040005);
    exec(1'b1, 32'h00020009);
    exec(1'b1, 32'h02060402);
    chk("t2_r4", {24'd0, dut.reg_8x8.regArr[4]}, 32'd5);
    chk("t2_r2", {24'd0, dut.reg_8x8.regArr[2]}, 32'd9);
    chk("t2_r6", {24'd0, dut.reg_8x8.regArr[6]}, 32'd14);
    chk("t2_model_r6", {24'd0, m_r[6]}, 32'd14);

    exec(1'b1, enc(8'h00, 1, 0, 8'h03));
    exec(1'b1, enc(8'h00, 2, 0, 8'h07));
    exec(1'b1, enc(8'h03, 3, 1, 8'h02));
    chk("t3_sub", {24'd0, dut.reg_8x8.regArr[3]}, 32'hFC);
    chk("t3_model_sub", {24'd0, m_r[3]}, 32'hFC);
    exec(1'b1, enc(8'h00, 1, 0, 8'hFF));
    exec(1'b1, enc(8'h00, 2, 0, 8'h02));
    exec(1'b1, enc(8'h02, 0, 1, 8'h02));
    chk("t3_add_wrap", {24'd0, dut.reg_8x8.regArr[0]}, 32'h01);

    exec(1'b1, enc(8'h00, 1, 0, 8'hF0));
    exec(1'b1, enc(8'h00, 2, 0, 8'h3C));
    exec(1'b1, enc(8'h04, 3, 1, 8'h02));
    chk("t4_and", {24'd0, dut.reg_8x8.regArr[3]}, 32'h30);
    exec(1'b1, enc(8'h05, 4, 1, 8'h02));
    chk("t4_or", {24'd0, dut.reg_8x8.regArr[4]}, 32'hFC);
    exec(1'b1, enc(8'h01, 5, 0, 8'h04));
    chk("t4_mov", {24'd0, dut.reg_8x8.regArr[5]}, 32'hFC);
    chk("t4_model_mov", {24'd0, m_r[5]}, 32'hFC);

    ins = m_pc;
    exec(1'b1, 32'h07050102);
    chk("t5_nop_pc", PC, ins + 32'd4);
    chk("t5_nop_r5", {24'd0, dut.reg_8x8.regArr[5]}, 32'hFC);
    exec(1'b0, enc(8'h00, 7, 0, 8'hAA));
    chk("t5_rst_r7", {24'd0, dut.reg_8x8.regArr[7]}, 32'h00);
    chk("t5_rst_pc", PC, 32'd0);
    exec(1'b1, 32'hFF00_0000);
    chk("t5_restart_pc", PC, 32'd4);

    exec(1'b1, enc(8'h00, 1, 0, 8'h41));
    exec(1'b1, enc(8'h02, 1, 1, 8'h01));
    chk("t6_self_add", {24'd0, dut.reg_8x8.regArr[1]}, 32'h82);
    chk("t6_model", {24'd0, m_r[1]}, 32'h82);

    for (int n = 0; n < 400; n++) begin
      ins = {8'($urandom_range(0, 7)), 5'($urandom), 3'($urandom),
             5'($urandom), 3'($urandom), 8'($urandom)};
      if ($urandom_range(0, 9) == 0) ins[31:24] = 8'($urandom);
      rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      exec(rst, ins);
    end

    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
